// File: rtl/cabac_dec_pkg.sv
// rtl/cabac_dec_pkg.sv - shared constants, encodings and probability tables for the CABAC decode engine
package cabac_dec_pkg;

    localparam logic [8:0] RANGE_INIT = 9'd510;
    localparam logic [4:0] INIT_BITS  = 5'd9;

    typedef enum logic [1:0] {
        MODE_REG  = 2'd0,
        MODE_BYP  = 2'd1,
        MODE_TRM  = 2'd2,
        MODE_BYP4 = 2'd3
    } bin_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } fsm_state_e;

    localparam logic [7:0] RLPS_TAB [0:63][0:3] = '{
        '{128, 176, 208, 240}, '{128, 167, 197, 227}, '{128, 158, 187, 216}, '{123, 150, 178, 205},
        '{116, 142, 169, 195}, '{111, 135, 160, 185}, '{105, 128, 152, 175}, '{100, 122, 144, 166},
        '{ 95, 116, 137, 158}, '{ 90, 110, 130, 150}, '{ 85, 104, 123, 142}, '{ 81,  99, 117, 135},
        '{ 77,  94, 111, 128}, '{ 73,  89, 105, 122}, '{ 69,  85, 100, 116}, '{ 66,  80,  95, 110},
        '{ 62,  76,  90, 104}, '{ 59,  72,  86,  99}, '{ 56,  69,  81,  94}, '{ 53,  65,  77,  89},
        '{ 51,  62,  73,  85}, '{ 48,  59,  69,  80}, '{ 46,  56,  66,  76}, '{ 43,  53,  63,  72},
        '{ 41,  50,  59,  69}, '{ 39,  48,  56,  65}, '{ 37,  45,  54,  62}, '{ 35,  43,  51,  59},
        '{ 33,  41,  48,  56}, '{ 32,  39,  46,  53}, '{ 30,  37,  43,  50}, '{ 29,  35,  41,  48},
        '{ 27,  33,  39,  45}, '{ 26,  31,  37,  43}, '{ 24,  30,  35,  41}, '{ 23,  28,  33,  39},
        '{ 22,  27,  32,  37}, '{ 21,  26,  30,  35}, '{ 20,  24,  29,  33}, '{ 19,  23,  27,  31},
        '{ 18,  22,  26,  30}, '{ 17,  21,  25,  28}, '{ 16,  20,  23,  27}, '{ 15,  19,  22,  25},
        '{ 14,  18,  21,  24}, '{ 14,  17,  20,  23}, '{ 13,  16,  19,  22}, '{ 12,  15,  18,  21},
        '{ 12,  14,  17,  20}, '{ 11,  14,  16,  19}, '{ 11,  13,  15,  18}, '{ 10,  12,  15,  17},
        '{ 10,  12,  14,  16}, '{  9,  11,  13,  15}, '{  9,  11,  12,  14}, '{  8,  10,  12,  14},
        '{  8,   9,  11,  13}, '{  7,   9,  11,  12}, '{  7,   9,  10,  12}, '{  7,   8,  10,  11},
        '{  6,   8,   9,  11}, '{  6,   7,   9,  10}, '{  6,   7,   8,   9}, '{  2,   2,   2,   2}
    };

    localparam logic [5:0] TRANS_LPS [0:63] = '{
         0,  0,  1,  2,  2,  4,  4,  5,  6,  7,  8,  9,  9, 11, 11, 12,
        13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
        24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
        33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
    };

    localparam logic [5:0] TRANS_MPS [0:63] = '{
         1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15, 16,
        17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32,
        33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 44, 45, 46, 47, 48,
        49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60, 61, 62, 62, 63
    };

    // One bypass step: returns {bin, new_offset}; the shifted offset needs 10 bits before the compare.
    function automatic logic [9:0] byp_step(input logic [8:0] off, input logic [8:0] rng, input logic b);
        logic [9:0] ext;
        logic       hit;
        ext = {off, b};
        hit = (ext >= {1'b0, rng});
        return {hit, hit ? 9'(ext - {1'b0, rng}) : ext[8:0]};
    endfunction

endpackage

// File: rtl/cabac_dec_engine_if.sv
// rtl/cabac_dec_engine_if.sv - bitstream feed and bin request/result bundle of the CABAC decode engine
interface cabac_dec_engine_if;
    logic       start;
    logic [7:0] bs_data;
    logic       bs_valid;
    logic       bs_ready;
    logic       bin_req;
    logic [1:0] bin_mode;
    logic [5:0] ctx_state;
    logic       ctx_mps;
    logic       bin_ready;
    logic       bin_valid;
    logic [3:0] bin_val;
    logic [5:0] ctx_state_new;
    logic       ctx_mps_new;
    logic       slice_done;

    modport slave (
        input  start, bs_data, bs_valid, bin_req, bin_mode, ctx_state, ctx_mps,
        output bs_ready, bin_ready, bin_valid, bin_val, ctx_state_new, ctx_mps_new, slice_done
    );

    modport master (
        output start, bs_data, bs_valid, bin_req, bin_mode, ctx_state, ctx_mps,
        input  bs_ready, bin_ready, bin_valid, bin_val, ctx_state_new, ctx_mps_new, slice_done
    );
endinterface

// File: rtl/cabac_dec_renorm.sv
// rtl/cabac_dec_renorm.sv - leading-zero renormalisation of range with offset refill from the bit buffer head
module cabac_dec_renorm (
    input  logic [8:0] range_in,
    input  logic [8:0] offset_in,
    input  logic [7:0] bits_in,
    output logic [8:0] range_out,
    output logic [8:0] offset_out,
    output logic [3:0] shift
);

    // Highest set bit wins; a zero range would report 9 but never occurs in a legal stream.
    always_comb begin
        shift = 4'd9;
        for (int i = 0; i < 9; i++) begin
            if (range_in[i]) begin
                shift = 4'(8 - i);
            end
        end
    end

    assign range_out  = range_in << shift;
    assign offset_out = 9'(({offset_in, bits_in} << shift) >> 8);

endmodule

// File: rtl/cabac_dec_engine.sv
// rtl/cabac_dec_engine.sv - CABAC binary arithmetic decode engine; CABAC_DEC_BYPASS4_EN enables 4-bin bypass mode
module cabac_dec_engine
    import cabac_dec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cabac_dec_engine_if.slave    io
);

    fsm_state_e  state_q, state_d;
    logic [8:0]  range_q, range_d;
    logic [8:0]  offset_q, offset_d;
    logic [15:0] buf_q, buf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bin_valid_q, bin_valid_d;
    logic [3:0]  bin_val_q, bin_val_d;
    logic [5:0]  ctx_state_new_q, ctx_state_new_d;
    logic        ctx_mps_new_q, ctx_mps_new_d;
    logic        slice_done_q, slice_done_d;

    logic        bs_ready, bin_ready, bs_hs, accept;
    bin_mode_e   mode;
    logic [7:0]  rlps;
    logic [8:0]  rmps, trm_range, pre_range, pre_offset;
    logic        reg_lps, trm_bin;
    logic [8:0]  norm_range, norm_offset;
    logic [3:0]  norm_shift, used;
    logic [9:0]  byp1;
    logic [4:0]  cnt_mid;
    logic [15:0] buf_shift;

    assign bs_ready  = (state_q != ST_IDLE) && (cnt_q <= 5'd8);
    assign bin_ready = (state_q == ST_READY) && (cnt_q >= 5'd7);
    assign bs_hs     = io.bs_valid && bs_ready;
    assign accept    = io.bin_req && bin_ready;
    assign mode      = bin_mode_e'(io.bin_mode);

    assign rlps      = RLPS_TAB[io.ctx_state][range_q[7:6]];
    assign rmps      = range_q - {1'b0, rlps};
    assign reg_lps   = (offset_q >= rmps);
    assign trm_range = range_q - 9'd2;
    assign trm_bin   = (offset_q >= trm_range);

    // Regular and terminate share one renormaliser; terminate only ever needs a 0/1 bit shift.
    assign pre_range  = (mode == MODE_TRM) ? trm_range : (reg_lps ? {1'b0, rlps} : rmps);
    assign pre_offset = (mode == MODE_TRM) ? offset_q  : (reg_lps ? offset_q - rmps : offset_q);

    cabac_dec_renorm u_renorm (
        .range_in   (pre_range),
        .offset_in  (pre_offset),
        .bits_in    (buf_q[15:8]),
        .range_out  (norm_range),
        .offset_out (norm_offset),
        .shift      (norm_shift)
    );

    assign byp1 = byp_step(offset_q, range_q, buf_q[15]);

`ifdef CABAC_DEC_BYPASS4_EN
    logic [9:0] byp2, byp3, byp4;
    assign byp2 = byp_step(byp1[8:0], range_q, buf_q[14]);
    assign byp3 = byp_step(byp2[8:0], range_q, buf_q[13]);
    assign byp4 = byp_step(byp3[8:0], range_q, buf_q[12]);
`endif

    always_comb begin
        state_d         = state_q;
        range_d         = range_q;
        offset_d        = offset_q;
        used            = 4'd0;
        bin_valid_d     = 1'b0;
        bin_val_d       = 4'd0;
        ctx_state_new_d = 6'd0;
        ctx_mps_new_d   = 1'b0;
        slice_done_d    = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (cnt_q >= INIT_BITS) begin
                    offset_d = buf_q[15:7];
                    used     = 4'(INIT_BITS);
                    state_d  = ST_READY;
                end
            end
            ST_READY: begin
                if (accept) begin
                    bin_valid_d = 1'b1;
                    case (mode)
                        MODE_REG: begin
                            range_d         = norm_range;
                            offset_d        = norm_offset;
                            used            = norm_shift;
                            bin_val_d       = {3'b000, reg_lps ? !io.ctx_mps : io.ctx_mps};
                            ctx_state_new_d = reg_lps ? TRANS_LPS[io.ctx_state] : TRANS_MPS[io.ctx_state];
                            ctx_mps_new_d   = (reg_lps && (io.ctx_state == 6'd0)) ? !io.ctx_mps : io.ctx_mps;
                        end
                        MODE_TRM: begin
                            range_d = trm_range;
                            if (trm_bin) begin
                                bin_val_d    = 4'd1;
                                slice_done_d = 1'b1;
                                state_d      = ST_IDLE;
                            end else begin
                                range_d  = norm_range;
                                offset_d = norm_offset;
                                used     = norm_shift;
                            end
                        end
`ifdef CABAC_DEC_BYPASS4_EN
                        MODE_BYP4: begin
                            offset_d  = byp4[8:0];
                            used      = 4'd4;
                            bin_val_d = {byp1[9], byp2[9], byp3[9], byp4[9]};
                        end
`endif
                        default: begin
                            offset_d  = byp1[8:0];
                            used      = 4'd1;
                            bin_val_d = {3'b000, byp1[9]};
                        end
                    endcase
                end
            end
            default: ;
        endcase

        // Consumption happens first, then an accepted byte lands right behind the remaining bits.
        cnt_mid   = cnt_q - {1'b0, used};
        buf_shift = buf_q << used;
        buf_d     = buf_shift;
        cnt_d     = cnt_mid;
        if (bs_hs) begin
            buf_d = buf_shift | ({io.bs_data, 8'h00} >> cnt_mid);
            cnt_d = cnt_mid + 5'd8;
        end

        if (io.start) begin
            state_d         = ST_INIT;
            range_d         = RANGE_INIT;
            offset_d        = 9'd0;
            buf_d           = 16'd0;
            cnt_d           = 5'd0;
            bin_valid_d     = 1'b0;
            bin_val_d       = 4'd0;
            ctx_state_new_d = 6'd0;
            ctx_mps_new_d   = 1'b0;
            slice_done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            range_q         <= RANGE_INIT;
            offset_q        <= 9'd0;
            buf_q           <= 16'd0;
            cnt_q           <= 5'd0;
            bin_valid_q     <= 1'b0;
            bin_val_q       <= 4'd0;
            ctx_state_new_q <= 6'd0;
            ctx_mps_new_q   <= 1'b0;
            slice_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            range_q         <= range_d;
            offset_q        <= offset_d;
            buf_q           <= buf_d;
            cnt_q           <= cnt_d;
            bin_valid_q     <= bin_valid_d;
            bin_val_q       <= bin_val_d;
            ctx_state_new_q <= ctx_state_new_d;
            ctx_mps_new_q   <= ctx_mps_new_d;
            slice_done_q    <= slice_done_d;
        end
    end

    assign io.bs_ready      = bs_ready;
    assign io.bin_ready     = bin_ready;
    assign io.bin_valid     = bin_valid_q;
    assign io.bin_val       = bin_val_q;
    assign io.ctx_state_new = ctx_state_new_q;
    assign io.ctx_mps_new   = ctx_mps_new_q;
    assign io.slice_done    = slice_done_q;

endmodule
